// File: rtl/seg10_pkg.sv
// Shared constants for the 10-segment display bus: widths and the pattern
// for every digit and for blank.
`timescale 1ns/1ps
package seg10_pkg;

    localparam int SEG_W   = 10;
    localparam int DIGIT_W = 4;

    localparam logic [SEG_W-1:0] SEG10_P0    = 10'b1111111100;
    localparam logic [SEG_W-1:0] SEG10_P1    = 10'b0011000000;
    localparam logic [SEG_W-1:0] SEG10_P2    = 10'b1110111011;
    localparam logic [SEG_W-1:0] SEG10_P3    = 10'b1111110011;
    localparam logic [SEG_W-1:0] SEG10_P4    = 10'b0011000111;
    localparam logic [SEG_W-1:0] SEG10_P5    = 10'b1101110111;
    localparam logic [SEG_W-1:0] SEG10_P6    = 10'b0001111111;
    localparam logic [SEG_W-1:0] SEG10_P7    = 10'b1111000000;
    localparam logic [SEG_W-1:0] SEG10_P8    = 10'b1111111111;
    localparam logic [SEG_W-1:0] SEG10_P9    = 10'b1111000111;
    localparam logic [SEG_W-1:0] SEG10_BLANK = 10'b0000000000;

endpackage

// File: rtl/seg10_match.sv
// Combinational inverse of the digit-to-segment table: classifies a 10-bit
// pattern as a digit, blank, or neither (both flags low).
`timescale 1ns/1ps
module seg10_match
    import seg10_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_digit,
    output logic               is_blank
);

    // Table lookup; unmatched patterns leave both flags low.
    always_comb begin
        digit    = 4'd0;
        is_digit = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG10_P0:    digit = 4'd0;
            SEG10_P1:    digit = 4'd1;
            SEG10_P2:    digit = 4'd2;
            SEG10_P3:    digit = 4'd3;
            SEG10_P4:    digit = 4'd4;
            SEG10_P5:    digit = 4'd5;
            SEG10_P6:    digit = 4'd6;
            SEG10_P7:    digit = 4'd7;
            SEG10_P8:    digit = 4'd8;
            SEG10_P9:    digit = 4'd9;
            SEG10_BLANK: begin
                is_digit = 1'b0;
                is_blank = 1'b1;
            end
            default: begin
                is_digit = 1'b0;
                is_blank = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seg10_reader.sv
// Segment-bus readback monitor: debounces segs_in over a stability window and
// decodes each newly committed pattern into digit / blank / error.
`timescale 1ns/1ps
module seg10_reader
    import seg10_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEG_W-1:0]   segs_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               blank,
    output logic               error,
    output logic               update,
    output logic [7:0]         err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W-1:0]   segs_q, segs_d;
    logic [SEG_W-1:0]   committed_q, committed_d;
    logic [CNT_W-1:0]   stab_cnt_q, stab_cnt_d;
    logic [DIGIT_W-1:0] digit_q, digit_d;
    logic               blank_q, blank_d;
    logic               error_q, error_d;
    logic               update_q, update_d;
    logic [7:0]         err_count_q, err_count_d;

    logic [DIGIT_W-1:0] match_digit_s;
    logic               match_is_digit_s;
    logic               match_is_blank_s;

    seg10_match u_match (
        .pattern  (segs_q),
        .digit    (match_digit_s),
        .is_digit (match_is_digit_s),
        .is_blank (match_is_blank_s)
    );

    // Sample/stability tracking and commit decision.
    always_comb begin
        segs_d      = segs_q;
        committed_d = committed_q;
        stab_cnt_d  = stab_cnt_q;
        digit_d     = digit_q;
        blank_d     = blank_q;
        error_d     = error_q;
        update_d    = 1'b0;
        err_count_d = err_count_q;
        if (segs_in != segs_q) begin
            segs_d     = segs_in;
            stab_cnt_d = '0;
        end else if (stab_cnt_q == CNT_COMMIT) begin
            stab_cnt_d = CNT_MAX;
            // Re-committing the same pattern is silent.
            if (segs_q != committed_q) begin
                committed_d = segs_q;
                update_d    = 1'b1;
                if (match_is_digit_s) begin
                    digit_d = match_digit_s;
                    blank_d = 1'b0;
                    error_d = 1'b0;
                end else if (match_is_blank_s) begin
                    blank_d = 1'b1;
                    error_d = 1'b0;
                end else begin
                    blank_d = 1'b0;
                    error_d = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end else begin
                        err_count_d = err_count_q;
                    end
                end
            end else begin
                committed_d = committed_q;
            end
        end else if (stab_cnt_q < CNT_MAX) begin
            stab_cnt_d = stab_cnt_q + 1'b1;
        end else begin
            stab_cnt_d = stab_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            segs_q      <= 10'b0000000000;
            committed_q <= 10'b0000000000;
            stab_cnt_q  <= '0;
            digit_q     <= 4'd0;
            blank_q     <= 1'b1;
            error_q     <= 1'b0;
            update_q    <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            segs_q      <= segs_d;
            committed_q <= committed_d;
            stab_cnt_q  <= stab_cnt_d;
            digit_q     <= digit_d;
            blank_q     <= blank_d;
            error_q     <= error_d;
            update_q    <= update_d;
            err_count_q <= err_count_d;
        end
    end

    assign digit     = digit_q;
    assign blank     = blank_q;
    assign error     = error_q;
    assign update    = update_q;
    assign err_count = err_count_q;

endmodule
